// File: rtl/demux_buf4_pkg.sv
// Shared constants and types for the 1-to-4 registered demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_buf4_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  localparam logic [31:0] ZERO_WORD = 32'd0;

  // One-entry buffer occupancy; the encoding doubles as the valid bit.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: loads a word on i_load, releases it when the consumer takes it.
// Latency: word loaded at edge N is valid after edge N; consumer may take it at edge N+1.
// Backpressure: o_rdy is low only while full and the consumer is not taking the word.
module demux_slot
  import demux_buf4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_rdy,
  output logic             o_rdy,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  slot_state_t      r_state;
  slot_state_t      w_state_nxt;
  logic             w_capture;
  logic [WIDTH-1:0] r_dat;

  // Occupancy register; reset empties the slot immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and capture strobe; a drain and a load in the same cycle keep the slot full.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      SLOT_EMPTY: begin
        if (i_load) begin
          w_state_nxt = SLOT_FULL;
          w_capture   = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (i_load) begin
          w_state_nxt = SLOT_FULL;
          w_capture   = 1'b1;
        end else if (i_out_rdy) begin
          w_state_nxt = SLOT_EMPTY;
        end
      end
      default: w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Data holding register; left untouched on drain since o_vld qualifies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dat <= WIDTH'(ZERO_WORD);
    end else if (w_capture) begin
      r_dat <= i_data;
    end
  end

  assign o_vld = (r_state == SLOT_FULL);
  assign o_rdy = (r_state == SLOT_EMPTY) | i_out_rdy;
  assign o_dat = r_dat;

endmodule

// File: rtl/demux_buf4.sv
// 1-to-4 registered demultiplexer: steers each accepted word into the one-entry buffer chosen by sel.
// Latency: one cycle from acceptance to out_valid on the selected channel; one word/cycle per channel.
// Backpressure: in_ready follows only the selected slot; a stalled channel never blocks the others.
module demux_buf4
  import demux_buf4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic [3:0]       out_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             busy
);

  logic [3:0]       w_slot_rdy;
  logic [3:0]       w_load;
  logic             w_accept;
  logic [WIDTH-1:0] w_dat [4];

  // Readiness of the addressed slot only; deliberately independent of in_valid.
  always_comb begin
    in_ready = 1'b0;
    case (sel)
      CH0:     in_ready = w_slot_rdy[0];
      CH1:     in_ready = w_slot_rdy[1];
      CH2:     in_ready = w_slot_rdy[2];
      CH3:     in_ready = w_slot_rdy[3];
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // Decode sel into a one-hot load strobe for the accepted word.
  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      w_load[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load[k]),
      .i_data    (in_data),
      .i_out_rdy (out_ready[k]),
      .o_rdy     (w_slot_rdy[k]),
      .o_vld     (out_valid[k]),
      .o_dat     (w_dat[k])
    );
  end

  assign out0 = w_dat[0];
  assign out1 = w_dat[1];
  assign out2 = w_dat[2];
  assign out3 = w_dat[3];
  assign busy = |out_valid;

endmodule

// File: tb/tb_demux_buf4.sv
// Directed bench for demux_buf4 with hand-computed expectations.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Backpressure: exercised through out_ready stalls on individual channels.
module tb_demux_buf4;

  logic        clk;
  logic        reset;
  logic [1:0]  sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [3:0]  out_ready;
  logic [3:0]  out_valid;
  logic [31:0] out0, out1, out2, out3;
  logic        busy;

  int n_chk;
  int n_pass;

  demux_buf4 #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b1;
    sel       = 2'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 4'b0000;

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_out0", out0, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Reset mid-operation with channels 1 and 3 full
    sel = 2'd1; in_data = 32'hAAAA0001; in_valid = 1'b1;
    step();
    sel = 2'd3; in_data = 32'h33333333;
    step();
    in_valid = 1'b0;
    chk("mid_full", 32'(out_valid), 32'hA);
    chk("mid_out1", out1, 32'hAAAA0001);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_out1", out1, 32'h0);
    chk("arst_out3", out3, 32'h0);
    chk("arst_ready", 32'(in_ready), 32'h1);
    #1;
    reset = 1'b0;
    step();

    // Single transfer to channel 2
    sel = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("one_valid", 32'(out_valid), 32'h4);
    chk("one_out2", out2, 32'hDEADBEEF);
    chk("one_busy", 32'(busy), 32'h1);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    chk("one_drain", 32'(out_valid), 32'h0);
    chk("one_hold", out2, 32'hDEADBEEF);

    // Backpressure on channel 0
    sel = 2'd0; in_data = 32'h11; in_valid = 1'b1;
    step();
    in_data = 32'h22;
    #1;
    chk("bp_ready_lo", 32'(in_ready), 32'h0);
    step();
    chk("bp_out0_held", out0, 32'h11);
    chk("bp_valid", 32'(out_valid), 32'h1);
    out_ready = 4'b0001;
    #1;
    chk("bp_ready_hi", 32'(in_ready), 32'h1);
    step();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    chk("bp_swap_out0", out0, 32'h22);
    chk("bp_swap_valid", 32'(out_valid), 32'h1);
    out_ready = 4'b0001;
    step();
    out_ready = 4'b0000;
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Independence: channel 1 stalled, traffic to channel 3
    sel = 2'd1; in_data = 32'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("ind_ch1_block", 32'(in_ready), 32'h0);
    sel = 2'd3; in_data = 32'h5A5A5A5A; in_valid = 1'b1;
    #1;
    chk("ind_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("ind_out3", out3, 32'h5A5A5A5A);
    chk("ind_out1", out1, 32'h77);
    chk("ind_valid", 32'(out_valid), 32'hA);
    out_ready = 4'b1111;
    step();
    out_ready = 4'b0000;
    chk("ind_drained", 32'(out_valid), 32'h0);

    // Streaming one word per cycle on channel 0
    out_ready = 4'b0001;
    sel = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      in_data  = 32'(i);
      in_valid = 1'b1;
      step();
      chk($sformatf("strm_out0_%0d", i), out0, 32'(i));
      chk($sformatf("strm_vld_%0d", i), 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_end_valid", 32'(out_valid), 32'h0);
    chk("strm_end_out0", out0, 32'h4);

    // Spurious ready with everything empty
    out_ready = 4'b1111;
    step();
    step();
    chk("spur_valid", 32'(out_valid), 32'h0);
    chk("spur_busy", 32'(busy), 32'h0);
    chk("spur_out0", out0, 32'h4);
    chk("spur_out3", out3, 32'h5A5A5A5A);
    out_ready = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_buf4.md
Name: demux_buf4

Overview:
- 1-to-4 registered demultiplexer with valid/ready flow control. It is the distributing counterpart of the datapath 4:1 selectors.
- One 32-bit source word is steered by a 2-bit select into one of four one-entry output buffers.
- Each buffer is drained independently by its own consumer.
- Used in the multicycle datapath to hand results (e.g. ALU, shifter, mult/div) to one of four destination stages without combinational fan-out glitches.

Parameters:
- WIDTH, 32, data width of input word and each output channel.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sel  input  2  destination channel for the current input word (0..3).
- in_valid  input  1  source presents a word on in_data.
- in_data  input  WIDTH  word to distribute.
- in_ready  output  1  block can accept the word this cycle (combinational).
- out_ready  input  4  bit k: consumer k takes out_k this cycle.
- out_valid  output  4  bit k: buffer k holds an undelivered word (registered).
- out0  output  WIDTH  buffer 0 contents (registered).
- out1  output  WIDTH  buffer 1 contents (registered).
- out2  output  WIDTH  buffer 2 contents (registered).
- out3  output  WIDTH  buffer 3 contents (registered).
- busy  output  1  OR of out_valid (combinational).

Behaviour:
- Reset (async, active-high):
  - out_valid = 4'b0000; out0..out3 = 0.
  - in_ready reflects the empty state, i.e. 1.
  - Reset asserted mid-transfer discards all buffered words immediately, without waiting for a clock edge.
- Per-channel state machine, channel k, two states:
  - EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
  - Definitions: acc_k = in_valid & in_ready & (sel==k); drn_k = out_valid[k] & out_ready[k].
  - EMPTY, acc_k -> FULL; out_k <= in_data.
  - FULL, drn_k & !acc_k -> EMPTY; out_k holds its last value.
  - FULL, drn_k & acc_k -> FULL; out_k <= in_data. This is back-to-back throughput, one word per cycle.
  - FULL, !drn_k -> FULL; out_k held, and no acceptance is possible on k.
- in_ready = !out_valid[sel] | out_ready[sel].
  - Depends only on the currently selected channel.
  - Has no dependency on in_valid.
- Latency: a word accepted at edge N is visible on out_sel with out_valid[sel]=1 after edge N; consumer may take it at edge N+1.
- Channels are independent:
  - Channels not selected may drain in the same cycle as an accept on another channel.
  - A full channel never blocks words addressed to other channels.
- out_ready[k] while out_valid[k]=0 is ignored. It causes no state change and no error.
- sel changes while in_valid=0 have no effect.
- A word is transferred only on the in_valid & in_ready edge.
- Source holding rule: while in_valid=1 and in_ready=0, the source keeps sel and in_data stable.
- No data is ever duplicated or dropped. Each accepted word is delivered exactly once, on exactly the channel given by sel at acceptance.
- out_k is not cleared on drain; only out_valid qualifies it.

Decomposition:
- Shared package holds:
  - the WIDTH default (32);
  - channel index constants CH0..CH3 = 2'd0..2'd3;
  - the 32-bit zero constant used for reset values.
- One sub-module, demux_slot: the one-entry buffer with load/drain/full logic, instantiated four times.
- The top level decodes sel to per-slot load strobes and forms in_ready with a 4:1 selection of slot readiness.

Test Plan:
- Reset mid-operation: reset=1 with channels 1 and 3 full -> out_valid=0000 and out0..out3=0 before the next clk edge; in_ready=1.
- Single transfer: sel=2, in_data=32'hDEADBEEF, in_valid=1 for one cycle -> next cycle out_valid=0100, out2=DEADBEEF; out_ready[2]=1 one cycle -> out_valid=0000, out2 still DEADBEEF.
- Backpressure: channel 0 full with 32'h11, out_ready=0000, sel=0, in_data=32'h22, in_valid=1 -> in_ready=0, out0 stays 11; raise out_ready[0] -> same edge drains 11 and loads 22, out_valid[0] stays 1.
- Independence: channel 1 full and stalled, sel=3, in_data=32'h5A5A5A5A -> in_ready=1, out3=5A5A5A5A next cycle, out1 unchanged.
- Streaming: sel=0 held, words 1,2,3,4 on consecutive cycles, out_ready[0]=1 throughout -> out0 shows 1,2,3,4 on consecutive cycles, out_valid[0]=1 for 4 cycles, then 0.
- Spurious ready: out_ready=1111 with all empty -> no state change, busy=0.
